// File: rtl/arp_resolver.sv
// arp_resolver: next-hop IPv4 to MAC resolver, client of the ARP cache query port.
// Optional macro ARP_RESOLVER_LAST_HIT_EN adds a one-entry last-hit bypass.
module arp_resolver #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_ip_i,
    output logic             query_req_valid_o,
    input  logic             query_req_ready_i,
    output logic [31:0]      query_ip_o,
    input  logic             query_resp_valid_i,
    output logic             query_resp_ready_o,
    input  logic [47:0]      query_mac_i,
    input  logic             query_err_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_ip_o,
    output logic [47:0]      res_mac_o,
    output logic             res_miss_o,
    output logic             res_timeout_o,
    output logic [CNT_W-1:0] miss_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUERY,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [15:0] LP_TMAX = 16'(TIMEOUT_CYCLES);

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_ip;
    logic [47:0]       r_mac;
    logic              r_miss;
    logic              r_timeout;
    logic              r_stale;
    logic [15:0]       r_timer;
    logic [CNT_W-1:0]  r_miss_count;

    logic w_req_hs;
    logic w_query_hs;
    logic w_in_wait;
    logic w_resp_take;
    logic w_stale_drop;
    logic w_expire;
    logic w_out_hs;
    logic w_hit;
    logic [47:0] w_hit_mac;

    assign w_req_hs     = (r_state == S_IDLE) & req_valid_i;
    assign w_query_hs   = (r_state == S_QUERY) & query_req_ready_i;
    assign w_in_wait    = (r_state == S_WAIT);
    // The response channel is always ready, so valid alone is a handshake.
    assign w_resp_take  = w_in_wait & query_resp_valid_i & ~r_stale;
    assign w_stale_drop = w_in_wait & query_resp_valid_i & r_stale;
    // Timer holds the number of WAIT cycles already spent; a response in
    // the expiry cycle wins over the timeout.
    assign w_expire     = w_in_wait & ~w_resp_take & (r_timer == LP_TMAX);
    assign w_out_hs     = (r_state == S_OUT) & res_ready_i;

`ifdef ARP_RESOLVER_LAST_HIT_EN
    logic        r_lh_valid;
    logic [31:0] r_lh_ip;
    logic [47:0] r_lh_mac;

    assign w_hit     = r_lh_valid & (req_ip_i == r_lh_ip);
    assign w_hit_mac = r_lh_mac;

    // Last-hit entry: load on clean responses, drop on any miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lh_valid <= 1'b0;
            r_lh_ip    <= '0;
            r_lh_mac   <= '0;
        end else if (w_resp_take && !query_err_i) begin
            r_lh_valid <= 1'b1;
            r_lh_ip    <= r_ip;
            r_lh_mac   <= query_mac_i;
        end else if (w_resp_take || w_expire) begin
            r_lh_valid <= 1'b0;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_mac = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_next = w_hit ? S_OUT : S_QUERY;
                end
            end
            S_QUERY: begin
                if (query_req_ready_i) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_resp_take || w_expire) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Descriptor, result, timer and stale bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ip      <= '0;
            r_mac     <= '0;
            r_miss    <= 1'b0;
            r_timeout <= 1'b0;
            r_stale   <= 1'b0;
            r_timer   <= '0;
        end else begin
            if (w_req_hs) begin
                r_ip <= req_ip_i;
                if (w_hit) begin
                    r_mac     <= w_hit_mac;
                    r_miss    <= 1'b0;
                    r_timeout <= 1'b0;
                end
            end
            if (w_query_hs) begin
                r_timer <= '0;
            end else if (w_in_wait && !w_resp_take && !w_expire) begin
                r_timer <= r_timer + 16'd1;
            end
            if (w_resp_take) begin
                r_mac     <= query_err_i ? 48'd0 : query_mac_i;
                r_miss    <= query_err_i;
                r_timeout <= 1'b0;
            end
            if (w_expire) begin
                r_mac     <= '0;
                r_miss    <= 1'b1;
                r_timeout <= 1'b1;
                r_stale   <= 1'b1;
            end else if (w_stale_drop) begin
                r_stale <= 1'b0;
            end
        end
    end

    // Saturating miss statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_count <= '0;
        end else if (w_out_hs && r_miss && !(&r_miss_count)) begin
            r_miss_count <= r_miss_count + 1'b1;
        end
    end

    assign req_ready_o        = (r_state == S_IDLE);
    assign query_req_valid_o  = (r_state == S_QUERY);
    assign query_ip_o         = r_ip;
    assign query_resp_ready_o = 1'b1;
    assign res_valid_o        = (r_state == S_OUT);
    assign res_ip_o           = r_ip;
    assign res_mac_o          = r_mac;
    assign res_miss_o         = r_miss;
    assign res_timeout_o      = r_timeout;
    assign miss_count_o       = r_miss_count;

endmodule
